// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM state type for the 16-by-8 restoring divider
package div_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = 8;
  localparam int STEP_CNT_W = 3;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step
//   r_i       partial remainder before the step (always < divisor)
//   bit_i     next dividend bit shifted in
//   divisor_i divisor
//   r_o       9-bit partial remainder after the step
//   q_o       quotient bit produced by the step
module div_restore_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   r_o,
  output logic                 q_o
);
  logic [DIVISOR_W:0] t;
  assign t   = {r_i, bit_i};
  assign q_o = t >= {1'b0, divisor_i};
  assign r_o = q_o ? t - {1'b0, divisor_i} : t;
endmodule

// File: rtl/divider16by8_seq.sv
// divider16by8_seq: sequential 16/8 unsigned restoring divider with valid/ready handshakes
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; dividend[15:0], divisor[7:0] sampled on acceptance
//   out_valid/out_ready   result handshake; quotient, remainder, ovf, dz held until transfer
//   DIV_ZERO_FLAG_EN      when defined, dz reports a zero divisor; otherwise dz is tied low
module divider16by8_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dz
);
  div_state_t            state_q;
  logic [QUOT_W-1:0]     lo_q, q_q;
  logic [DIVISOR_W-1:0]  divisor_q, r_q;
  logic [STEP_CNT_W-1:0] cnt_q;
  logic                  ovf_q, out_valid_q, q_bit;
  logic [DIVISOR_W:0]    r_d;
  logic                  accept, big;
  assign accept = state_q == IDLE && in_valid;
  assign big    = dividend[DIVIDEND_W-1:QUOT_W] >= divisor;
  div_restore_step u_step (
    .r_i      (r_q),
    .bit_i    (lo_q[QUOT_W-1]),
    .divisor_i(divisor_q),
    .r_o      (r_d),
    .q_o      (q_bit)
  );
  // R stays below the divisor between steps, so its ninth bit is always zero
  // and only the low byte is stored.
  always_comb if (state_q == CALC) assert (!r_d[DIVISOR_W]);
  // out_valid is raised one edge after entering DONE on the overflow path and
  // together with DONE on the last CALC step, giving 1 and 8 cycle latencies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          lo_q      <= dividend[QUOT_W-1:0];
          divisor_q <= divisor;
          cnt_q     <= '0;
          ovf_q     <= big;
          q_q       <= big ? '1 : '0;
          r_q       <= big ? dividend[QUOT_W-1:0] : dividend[DIVIDEND_W-1:QUOT_W];
          state_q   <= big ? DONE : CALC;
        end
        CALC: begin
          r_q   <= r_d[DIVISOR_W-1:0];
          q_q   <= {q_q[QUOT_W-2:0], q_bit};
          lo_q  <= {lo_q[QUOT_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_valid_q && out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef DIV_ZERO_FLAG_EN
  logic dz_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dz_q <= 1'b0;
    else if (accept) dz_q <= divisor == '0;
  end
  assign dz = dz_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign dz = 1'b0;
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign quotient  = q_q;
  assign remainder = r_q;
  assign ovf       = ovf_q;
endmodule
